// File: rtl/sdram_port_arbiter_pkg.sv
// sdram_port_arbiter_pkg: shared widths and FSM/owner types for the SDRAM port arbiter
package sdram_port_arbiter_pkg;
  localparam int SDRAM_ADDR_W = 25;
  localparam int SDRAM_DATA_W = 16;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_ME} arb_owner_t;
endpackage

// File: rtl/sdram_port_arbiter_select.sv
// sdram_arb_select: ME-over-IF winner selection; SDRAM_ARB_STARVE_GUARD_EN adds an IF starvation guard
module sdram_arb_select
  import sdram_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
`ifdef SDRAM_ARB_STARVE_GUARD_EN
  input  logic       clock,
  input  logic       reset,
  input  logic       arb_en,
`endif
  input  logic       if_req,
  input  logic       me_req,
  output logic       any_req,
  output arb_owner_t winner
);
`ifdef SDRAM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          starve;
  // ME wins unless IF has lost STARVE_LIMIT arbitrations in a row; count IF losses while it waits
  always_comb begin
    any_req = if_req | me_req;
    starve  = cnt_q == CW'(STARVE_LIMIT);
    winner  = me_req && !(starve && if_req) ? OWN_ME : OWN_IF;
    cnt_d   = !arb_en ? cnt_q : (!if_req || winner == OWN_IF) ? '0 : starve ? cnt_q : cnt_q + 1'b1;
  end
  // starvation counter register
  always_ff @(posedge clock) cnt_q <= reset ? '0 : cnt_d;
`else
  // strict priority: ME holds the older instruction, so it always wins a tie
  always_comb begin
    any_req = if_req | me_req;
    winner  = me_req ? OWN_ME : OWN_IF;
  end
`endif
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM controller port between IF (read) and ME (read/write); optional SDRAM_ARB_STARVE_GUARD_EN
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = SDRAM_ADDR_W,
  parameter int DATA_W       = SDRAM_DATA_W,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              me_req,
  input  logic              me_we,
  input  logic [ADDR_W-1:0] me_addr,
  input  logic [DATA_W-1:0] me_wdata,
  output logic              me_done,
  output logic [DATA_W-1:0] me_rdata,
  output logic              mem_req,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);
  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d, winner;
  logic              any_req, sample, fin, rd_fin;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic              if_done_q, if_done_d, me_done_q, me_done_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, me_rdata_q, me_rdata_d;

  sdram_arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_select (
`ifdef SDRAM_ARB_STARVE_GUARD_EN
    .clock  (clock),
    .reset  (reset),
    .arb_en (state_q == IDLE),
`endif
    .if_req (if_req),
    .me_req (me_req),
    .any_req(any_req),
    .winner (winner)
  );

  // state register
  always_ff @(posedge clock) state_q <= reset ? IDLE : state_d;

  // next state: controller inputs only matter in the state that consumes them
  always_comb begin
    state_d = state_q == IDLE  ? (any_req ? ISSUE : IDLE) :
              state_q == ISSUE ? (!mem_ready ? ISSUE : mem_we_q ? RESP : WAIT) :
              state_q == WAIT  ? (mem_rvalid ? RESP : WAIT) : IDLE;
  end

  // outputs: latch the winner's fields on a grant, pulse done one cycle after completion
  always_comb begin
    sample      = state_q == IDLE && any_req;
    rd_fin      = state_q == WAIT && mem_rvalid;
    fin         = rd_fin || (state_q == ISSUE && mem_ready && mem_we_q);
    owner_d     = sample ? winner : owner_q;
    mem_req_d   = sample || (state_q == ISSUE && !mem_ready);
    mem_we_d    = sample ? winner == OWN_ME && me_we : mem_we_q;
    mem_addr_d  = sample ? (winner == OWN_ME ? me_addr : if_addr) : mem_addr_q;
    mem_wdata_d = sample ? (winner == OWN_ME ? me_wdata : '0) : mem_wdata_q;
    if_done_d   = fin && owner_q == OWN_IF;
    me_done_d   = fin && owner_q == OWN_ME;
    if_rdata_d  = rd_fin && owner_q == OWN_IF ? mem_rdata : if_rdata_q;
    me_rdata_d  = rd_fin && owner_q == OWN_ME ? mem_rdata : me_rdata_q;
  end

  // datapath and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q     <= OWN_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      me_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      me_rdata_q  <= '0;
    end else begin
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      me_done_q   <= me_done_d;
      if_rdata_q  <= if_rdata_d;
      me_rdata_q  <= me_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_done   = if_done_q;
  assign me_done   = me_done_q;
  assign if_rdata  = if_rdata_q;
  assign me_rdata  = me_rdata_q;
endmodule
